tx_msg_sequencer: RTL
=====================

# tx_msg_sequencer

Controller that streams a fixed-length ASCII status message out of a synchronous message ROM into the UART transmitter, one byte per valid/ready handshake. It replaces free-running stepping of the message memory on the baud-rate strobe with explicit sequencing: start, per-byte fetch, back-pressure from the transmitter, abort, and optional repeat. Sits between the system control logic (start/abort/repeat), the message ROM (address out, data in), and the UART TX byte interface.

## Interface
- MSG_LEN, 26, number of bytes in one message pass (1..2^ADDR_W)
- ADDR_W, 5, ROM address width
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- iSTART  input  1  request one message pass; level-sampled, honoured only in IDLE
- iABORT  input  1  terminate current pass; priority over all other inputs except reset
- iREPEAT  input  1  when high at end of pass, start next pass without returning to IDLE
- oROM_ADDR  output  ADDR_W  ROM read address
- iROM_DATA  input  8  ROM read data, valid the cycle after oROM_ADDR is presented in READ
- oTX_DATA  output  8  byte to transmitter, stable while oTX_VALID high
- oTX_VALID  output  1  byte offered to transmitter
- iTX_READY  input  1  transmitter accepts byte when oTX_VALID && iTX_READY at rising edge
- oBUSY  output  1  high in any state other than IDLE
- oDONE  output  1  one-cycle pulse after last byte of a pass is accepted

## Operation
- States: IDLE, READ, LATCH, SEND.
- IDLE: oBUSY=0. iSTART=1 (and iABORT=0) -> addr<=0, go READ.
- READ: oROM_ADDR=addr presented to ROM; go LATCH.
- LATCH: oTX_DATA<=iROM_DATA, oTX_VALID<=1; go SEND.
- SEND: hold oTX_DATA/oTX_VALID until iTX_READY=1. On handshake: oTX_VALID<=0;
  - addr != MSG_LEN-1: addr<=addr+1, go READ.
  - addr == MSG_LEN-1: oDONE<=1 for one cycle; iREPEAT=1 -> addr<=0, go READ; else go IDLE.
- Address arithmetic unsigned ADDR_W bits; never exceeds MSG_LEN-1, no wrap past it.
- iABORT=1 in READ/LATCH/SEND: next state IDLE, oTX_VALID<=0, addr<=0, no oDONE. If iABORT and handshake occur at the same edge, byte counts as delivered but sequence still stops; no oDONE even on last byte.
- iSTART while busy ignored (not queued). iSTART and iABORT both high in IDLE: stay IDLE.
- oTX_DATA never changes while oTX_VALID=1; oTX_VALID never drops without handshake except on abort/reset.

## Timing
- Reset values: state IDLE, oROM_ADDR=0, oTX_DATA=8'h00, oTX_VALID=0, oBUSY=0, oDONE=0.
- Reset mid-pass: all outputs to reset values on the next edge; in-flight byte discarded.
- iSTART sampled at edge E -> READ during cycle E+1, oTX_VALID high from edge E+2.
- Per-byte minimum period with iTX_READY held high: 3 cycles (READ, LATCH, SEND).
- Full pass with iTX_READY held high: 3*MSG_LEN cycles from first READ to oDONE pulse; oDONE asserted in the cycle following the final handshake edge, concurrent with IDLE (or READ if repeating).
- oBUSY is registered state decode: high from edge after accepted iSTART through the edge returning to IDLE.
- ROM assumed 1-cycle synchronous read; no other latency is tolerated.

## Test plan
- Reset then iSTART pulse, iTX_READY=1, ROM loaded with "current state:rate control" -> 26 bytes emitted in order (0x63 first, 0x6C last), one every 3 cycles, oDONE single pulse 78 cycles after first READ, then oBUSY=0.
- Back-pressure: iTX_READY low for 10 cycles during byte 5 -> oTX_DATA/oTX_VALID held constant for all 10 cycles, byte 5 delivered exactly once, no skipped or duplicated bytes.
- Abort at byte 12 in SEND with simultaneous handshake -> byte 12 delivered, oTX_VALID=0 and oBUSY=0 next edge, no oDONE; following iSTART restarts at address 0.
- iREPEAT=1 with MSG_LEN=4 -> continuous addresses 0,1,2,3,0,1,...; oDONE pulses once per pass; deassert iREPEAT -> stops after current pass.
- iSTART re-asserted mid-pass and iSTART+iABORT together in IDLE -> no effect on sequence; stays IDLE respectively.
- Synchronous reset asserted in LATCH -> all outputs at reset values after that edge, no oTX_VALID glitch; asynchronous-looking reset pulse not aligned to an edge has no effect.

Source files
------------

// File: rtl/tx_msg_sequencer.sv
// Streams a fixed-length message from a 1-cycle synchronous ROM to a UART TX
// byte interface using valid/ready, with start, abort and repeat control.
module tx_msg_sequencer #(
  parameter int MSG_LEN = 26,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iSTART,
  input  logic              iABORT,
  input  logic              iREPEAT,
  output logic [ADDR_W-1:0] oROM_ADDR,
  input  logic [7:0]        iROM_DATA,
  output logic [7:0]        oTX_DATA,
  output logic              oTX_VALID,
  input  logic              iTX_READY,
  output logic              oBUSY,
  output logic              oDONE
);

  typedef enum logic [1:0] {IDLE, READ, LATCH, SEND} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  // Abort outranks everything once busy; a byte handshaking on the abort edge
  // is still delivered, but the pass ends without a done pulse.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;

    if (state_q != IDLE && iABORT) begin
      state_d    = IDLE;
      addr_d     = '0;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iSTART && !iABORT) begin
            addr_d  = '0;
            state_d = READ;
          end
        end
        READ: begin
          state_d = LATCH;
        end
        LATCH: begin
          tx_data_d  = iROM_DATA;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
        SEND: begin
          if (iTX_READY) begin
            tx_valid_d = 1'b0;
            if (addr_q == LAST_ADDR) begin
              done_d  = 1'b1;
              addr_d  = '0;
              state_d = iREPEAT ? READ : IDLE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = READ;
            end
          end
        end
      endcase
    end
  end

  assign oROM_ADDR = addr_q;
  assign oTX_DATA  = tx_data_q;
  assign oTX_VALID = tx_valid_q;
  assign oBUSY     = (state_q != IDLE);
  assign oDONE     = done_q;

endmodule
